// File: rtl/fnd_scan_controller_if.sv
// Host-side bundle for the FND scan controller: value/strobe/enable in,
// digit enables, segment lines and busy flag out.
interface fnd_scan_controller_if;
    logic [13:0] i_value;
    logic        i_load;
    logic        i_en;
    logic [3:0]  o_digit;
    logic [7:0]  o_fndFont;
    logic        o_busy;

    // Host / datapath side: drives value, strobe and enable.
    modport master (
        output i_value, i_load, i_en,
        input  o_digit, o_fndFont, o_busy
    );

    // Display controller side.
    modport slave (
        input  i_value, i_load, i_en,
        output o_digit, o_fndFont, o_busy
    );
endinterface

// File: rtl/fnd_scan_controller.sv
// Time-multiplexed 4-digit common-anode FND driver. A 14-bit value is
// captured on a strobe, clamped to 9999, converted to BCD by a sequential
// double-dabble engine (one bit per cycle), then scanned out one digit at a
// time onto shared active-low segment lines.
module fnd_scan_controller #(
    parameter int CLK_DIV       = 100000,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    fnd_scan_controller_if.slave  bus
);

    localparam int           PW         = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

    typedef enum logic {IDLE, CONV} state_t;

    state_t      state, state_next;
    logic [13:0] bin_q;
    logic [15:0] bcd_q;
    logic [15:0] bcd_adj;
    logic [15:0] bcd_shift;
    logic [3:0]  shift_cnt;
    logic        conv_last;
    logic        load_accept;
    logic [15:0] disp_q;
    logic        ovf_q;
    logic [PW-1:0] presc_q;
    logic [1:0]  idx_q;
    logic [15:0] disp_upper;
    logic [3:0]  cur_nibble;
    logic [7:0]  font_next;
    logic [3:0]  digit_q;
    logic [7:0]  font_q;
    logic        busy;

    function automatic logic [7:0] seg_font(input logic [3:0] n);
        case (n)
            4'd0:    return 8'hC0;
            4'd1:    return 8'hF9;
            4'd2:    return 8'hA4;
            4'd3:    return 8'hB0;
            4'd4:    return 8'h99;
            4'd5:    return 8'h92;
            4'd6:    return 8'h82;
            4'd7:    return 8'hF8;
            4'd8:    return 8'h80;
            4'd9:    return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    // The 14th iteration happens on the edge where the count reads 13.
    assign conv_last   = (shift_cnt == 4'd13);
    assign load_accept = (state == IDLE) && bus.i_load;

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (!i_reset_n) state <= IDLE;
        else            state <= state_next;
    end

    // FSM next-state logic; loads during CONV are dropped, not queued.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_next
        // unassigned, which would infer a latch.
        state_next = state;
        case (state)
            IDLE: if (bus.i_load) state_next = CONV;
            CONV: if (conv_last)  state_next = IDLE;
            default:              state_next = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy = (state == CONV);
    end

    // Double-dabble correction: add 3 to each BCD nibble that is 5 or more.
    always_comb begin
        bcd_adj = bcd_q;
        for (int k = 0; k < 4; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5)
                bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
        end
        bcd_shift = {bcd_adj[14:0], bin_q[13]};
    end

    // Conversion datapath: capture/clamp on load, shift while converting,
    // publish all four digits at once on the final iteration.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        // NOTE: display and overflow registers are reset so a conversion
        // aborted by reset leaves the display at a clean 0.
        if (!i_reset_n) begin
            bin_q     <= '0;
            bcd_q     <= '0;
            shift_cnt <= '0;
            disp_q    <= '0;
            ovf_q     <= 1'b0;
        end else if (load_accept) begin
            bin_q     <= (bus.i_value > 14'd9999) ? 14'd9999 : bus.i_value;
            ovf_q     <= (bus.i_value > 14'd9999);
            bcd_q     <= '0;
            shift_cnt <= '0;
        end else if (state == CONV) begin
            bcd_q     <= bcd_shift;
            bin_q     <= {bin_q[12:0], 1'b0};
            shift_cnt <= shift_cnt + 4'd1;
            if (conv_last) disp_q <= bcd_shift;
        end
    end

    // Free-running scan prescaler and digit index.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            presc_q <= '0;
            idx_q   <= '0;
        end else if (presc_q == PRESC_MAX) begin
            presc_q <= '0;
            idx_q   <= idx_q + 2'd1;
        end else begin
            presc_q <= presc_q + PW'(1);
        end
    end

    // Font for the indexed digit, with leading-zero blanking and overflow dp.
    always_comb begin
        disp_upper = disp_q >> {idx_q, 2'b00};
        cur_nibble = disp_upper[3:0];
        font_next  = seg_font(cur_nibble);
        if (BLANK_LEADING && (idx_q != 2'd0) && (disp_upper == 16'd0))
            font_next = 8'hFF;
        if (ovf_q && (idx_q == 2'd3))
            font_next[7] = 1'b0;
    end

    // Registered outputs so digit enables never glitch between codes.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            digit_q <= 4'hF;
            font_q  <= 8'hFF;
        end else if (bus.i_en) begin
            digit_q <= ~(4'b0001 << idx_q);
            font_q  <= font_next;
        end else begin
            digit_q <= 4'hF;
            font_q  <= 8'hFF;
        end
    end

    assign bus.o_digit   = digit_q;
    assign bus.o_fndFont = font_q;
    assign bus.o_busy    = busy;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Self-checking bench for fnd_scan_controller. Two instances (with and
// without leading-zero blanking) see identical stimulus; expected outputs
// come from a decimal-arithmetic model of the display.
module tb_fnd_scan_controller;

    localparam int CLK_DIV = 4;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    fnd_scan_controller_if bus();
    fnd_scan_controller_if bus_nb();

    fnd_scan_controller #(.CLK_DIV(CLK_DIV), .BLANK_LEADING(1'b1)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    fnd_scan_controller #(.CLK_DIV(CLK_DIV), .BLANK_LEADING(1'b0)) dut_nb (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus_nb)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    // Reference model state.
    int         edge_n;
    int         disp_val;
    int         pend_val;
    int         busy_left;
    bit         disp_ovf;
    logic [3:0] exp_digit;
    logic [7:0] exp_font;
    logic [7:0] exp_font_nb;
    logic       exp_busy;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_font(input int v, input int k, input bit blank, input bit ovf);
        int         pw;
        logic [7:0] f;
        pw = 1;
        for (int i = 0; i < k; i++) pw = pw * 10;
        f = seg_tab[(v / pw) % 10];
        if (blank && k > 0 && v < pw) f = 8'hFF;
        if (ovf && k == 3) f[7] = 1'b0;
        return f;
    endfunction

    task automatic model_reset();
        edge_n      = 0;
        disp_val    = 0;
        pend_val    = 0;
        disp_ovf    = 1'b0;
        busy_left   = 0;
        exp_digit   = 4'hF;
        exp_font    = 8'hFF;
        exp_font_nb = 8'hFF;
        exp_busy    = 1'b0;
    endtask

    // One rising edge of the model: outputs reflect pre-edge state.
    task automatic model_step(input bit load, input int value, input bit en);
        int idx;
        idx = (edge_n / CLK_DIV) % 4;
        if (en) begin
            exp_digit   = 4'hF & ~(4'b0001 << idx);
            exp_font    = model_font(disp_val, idx, 1'b1, disp_ovf);
            exp_font_nb = model_font(disp_val, idx, 1'b0, disp_ovf);
        end else begin
            exp_digit   = 4'hF;
            exp_font    = 8'hFF;
            exp_font_nb = 8'hFF;
        end
        if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) disp_val = pend_val;
        end else if (load) begin
            pend_val  = (value > 9999) ? 9999 : value;
            disp_ovf  = (value > 9999);
            busy_left = 14;
        end
        exp_busy = (busy_left > 0);
        edge_n++;
    endtask

    task automatic drive(input bit load, input int value, input bit en);
        logic [13:0] v14;
        v14 = value[13:0];
        bus.i_load      = load;
        bus.i_value     = v14;
        bus.i_en        = en;
        bus_nb.i_load   = load;
        bus_nb.i_value  = v14;
        bus_nb.i_en     = en;
    endtask

    // Apply inputs (called at a falling edge), clock once, compare.
    task automatic cycle(input bit load, input int value, input bit en);
        drive(load, value, en);
        @(posedge clk);
        model_step(load, value, en);
        @(negedge clk);
        check("digit",    bus.o_digit,      exp_digit);
        check("font",     bus.o_fndFont,    exp_font);
        check("busy",     bus.o_busy,       exp_busy);
        check("digit_nb", bus_nb.o_digit,   exp_digit);
        check("font_nb",  bus_nb.o_fndFont, exp_font_nb);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_digit"}, bus.o_digit,      16'hF);
        check({tag, "_font"},  bus.o_fndFont,    16'hFF);
        check({tag, "_busy"},  bus.o_busy,       16'h0);
        check({tag, "_nb_digit"}, bus_nb.o_digit,   16'hF);
        check({tag, "_nb_font"},  bus_nb.o_fndFont, 16'hFF);
    endtask

    task automatic idle_cycles(input int n, input bit en);
        for (int i = 0; i < n; i++) cycle(1'b0, 0, en);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 0, 1'b1);
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;

        // Blank display scan: C0 on digit0, FF elsewhere, 4 cycles per digit.
        idle_cycles(8 * CLK_DIV, 1'b1);

        // 1234, with busy for 14 cycles.
        cycle(1'b1, 1234, 1'b1);
        idle_cycles(14 + 8 * CLK_DIV, 1'b1);

        // Single digit: blanking vs. no blanking.
        cycle(1'b1, 7, 1'b1);
        idle_cycles(14 + 4 * CLK_DIV, 1'b1);

        // Clamp to 9999 with dp, then a small value clears the dp.
        cycle(1'b1, 12000, 1'b1);
        idle_cycles(14 + 4 * CLK_DIV, 1'b1);
        cycle(1'b1, 5, 1'b1);
        idle_cycles(14 + 4 * CLK_DIV, 1'b1);

        // Load during conversion is ignored; then display disable.
        cycle(1'b1, 1234, 1'b1);
        idle_cycles(4, 1'b1);
        cycle(1'b1, 4321, 1'b1);
        idle_cycles(8, 1'b1);
        cycle(1'b1, 4321, 1'b1);  // lands on the final conversion edge
        idle_cycles(4 * CLK_DIV, 1'b1);
        idle_cycles(2 * CLK_DIV + 1, 1'b0);
        idle_cycles(4 * CLK_DIV, 1'b1);

        // Asynchronous reset mid-conversion.
        cycle(1'b1, 9999, 1'b1);
        idle_cycles(6, 1'b1);
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        model_reset();
        @(negedge clk);
        check_reset_values("reset_hold");
        rst_n = 1'b1;
        idle_cycles(4 * CLK_DIV, 1'b1);

        // Randomized loads, values and enables.
        for (int i = 0; i < 3000; i++) begin
            int v;
            bit ld;
            bit en;
            ld = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 3))
                0:       v = int'($urandom_range(0, 16383));
                1:       v = int'($urandom_range(9990, 10010));
                2:       v = int'($urandom_range(0, 99));
                default: v = int'($urandom_range(0, 9999));
            endcase
            en = ($urandom_range(0, 9) != 0);
            cycle(ld, v, en);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fnd_scan_controller.md
# fnd_scan_controller

Time-multiplexed driver for a 4-digit common-anode FND. It sits downstream of the adder/subtractor datapath and replaces static digit selection with automatic scanning. A 14-bit binary value is latched on a strobe and converted to four BCD digits by a sequential double-dabble engine. The digits are then refreshed one at a time onto shared segment lines.

## Interface
- `CLK_DIV`, default 100000: clock cycles each digit stays lit; legal range 2 and up.
- `BLANK_LEADING`, default 1: 1 blanks leading zeros, 0 shows all four digits.
- `i_clk`  in  1: single system clock; all state changes on its rising edge.
- `i_reset_n`  in  1: reset, asynchronous assert, active-low.
- `i_value`  in  14: unsigned binary value to display.
- `i_load`  in  1: capture strobe; sampled every cycle.
- `i_en`  in  1: display enable; 0 blanks all outputs.
- `o_digit`  out  4: digit enables, one-hot active-low; bit0 = ones digit, bit3 = thousands digit.
- `o_fndFont`  out  8: segments, active-low; bit0..6 = a..g, bit7 = dp.
- `o_busy`  out  1: conversion in progress.

## Operation
- **States**: IDLE and CONV.
- **IDLE → CONV**: when `i_load`=1 in IDLE:
  - latch `i_value`, clamped to 9999 if greater;
  - set the internal overflow flag to 1 if clamping occurred, else clear it;
  - clear the BCD shift register and set the shift count to 0.
- **CONV**:
  - one double-dabble iteration per cycle: add 3 to every BCD nibble that is ≥5, then shift the BCD register and binary register left by 1;
  - after exactly 14 iterations, copy the four nibbles to the display registers (all four at once) and return to IDLE.
- `i_load` during CONV is ignored; it is not queued.
- The display registers hold the previous value for the whole conversion.
- **Scan**:
  - a prescaler counts 0..`CLK_DIV`−1 and wraps;
  - on its terminal count the digit index advances 0→1→2→3→0;
  - the prescaler and index run continuously, regardless of `i_en` or FSM state.
- **Font codes**, 0–9, with dp off: C0, F9, A4, B0, 99, 92, 82, F8, 80, 90 (hex).
  - Nibble values above 9 cannot occur; if they do, display FF.
- **Leading-zero blanking** (`BLANK_LEADING`=1): digit k>0 shows FF if it and every higher digit are 0. The ones digit is never blanked, so value 0 shows "0".
- **Overflow**: when the flag is set, bit7 of the font is driven 0 (dp lit) while digit 3 is active. The dp is lit even if digit 3 is blanked.
- **Outputs**:
  - `i_en`=1: `o_digit` = ~(1<<index) and `o_fndFont` = font of the indexed digit.
  - `i_en`=0: `o_digit`=1111 and `o_fndFont`=FF.
- **Reset values**: `o_digit`=1111, `o_fndFont`=FF, `o_busy`=0, FSM=IDLE, display registers 0, overflow flag 0, index 0, prescaler 0.
- Reset asserted mid-conversion aborts it; the display shows 0 after release.

## Timing
- Load accepted on edge E0. `o_busy`=1 from after E0 until after E14, i.e. high for exactly 14 cycles.
- Display registers update on E14. A new load can be accepted on E15.
- `o_digit` and `o_fndFont` are registered:
  - they reflect index, display registers and `i_en` one cycle after those change;
  - the new value therefore first appears on E15;
  - `i_en` takes effect one cycle after it changes.
- Each digit is lit for exactly `CLK_DIV` cycles; a full frame is 4×`CLK_DIV` cycles.
- No glitch states: `o_digit` is always all-ones or exactly one zero.
- A load in the same cycle as the end of a conversion (E14) is ignored.

## Test plan
All scenarios use `CLK_DIV`=4.
1. Reset with `i_en`=1 → `o_digit`=1111, `o_fndFont`=FF, `o_busy`=0. After release, the scan shows C0 on digit0 and FF on digits 1–3. The `o_digit` sequence is 1110, 1101, 1011, 0111, each held 4 cycles.
2. Load 1234 → `o_busy` high for 14 cycles. The following frame shows 99, B0, A4, F9 on digits 0–3.
3. Load 7 → digit0 shows F8 and digits 1–3 show FF. With `BLANK_LEADING`=0, digits 1–3 show C0.
4. Load 12000 → display 9999: digits 0–2 show 90 and digit3 shows 10 (dp lit). A following load of 5 clears the dp.
5. Load 1234, then pulse `i_load` with 4321 at busy cycle 5 → 1234 is displayed and `o_busy` falls on schedule. Drop `i_en` → both outputs read 1111 and FF from the next cycle while the index keeps advancing.
6. Reset asserted at busy cycle 7 of loading 9999 → outputs take their reset values immediately (asynchronously). After release, digit0 shows C0.
